// File: rtl/rs232_receive.sv
// UART receiver: 8N1, LSB first, 2-of-3 majority sampling at mid-bit.
// Emits a one-cycle O_Valid per good byte or O_Frame_Err per bad stop bit.
//
// state | meaning
// IDLE  | line idle, waiting for a 1->0 edge on the synchronised line
// START | timing the start bit; a high majority means a glitch
// DATA  | timing and sampling the eight data bits
// STOP  | sampling the stop bit; leaves at its decision point
module rs232_receive #(
  parameter int P_CLK_FREQ  = 50_000_000,
  parameter int P_RS232_BPS = 115200
) (
  input  logic       I_Clk,
  input  logic       I_Rst_N,
  input  logic       I_Rxd,
  output logic [7:0] O_Data,
  output logic       O_Valid,
  output logic       O_Frame_Err,
  output logic       O_Busy
);

  // P_BPS_CNT must lie in 8..65535 so the three sample points sit before the bit end.
  localparam int P_BPS_CNT = P_CLK_FREQ / P_RS232_BPS;
  localparam int P_HALF    = P_BPS_CNT / 2;

  localparam logic [15:0] C_LAST = 16'(P_BPS_CNT - 1);
  localparam logic [15:0] C_SMP0 = 16'(P_HALF - 1);
  localparam logic [15:0] C_SMP1 = 16'(P_HALF);
  localparam logic [15:0] C_DEC  = 16'(P_HALF + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t      state, state_nxt;
  logic [15:0] cnt, cnt_nxt;
  logic [2:0]  idx, idx_nxt;
  logic [1:0]  smp, smp_nxt;
  logic [7:0]  shreg, shreg_nxt;
  logic [7:0]  data, data_nxt;
  logic        valid, valid_nxt;
  logic        ferr, ferr_nxt;

  logic s0, s1, s2;
  logic fall;
  logic maj;
  logic bit_end;
  logic dec;

  always_ff @(posedge I_Clk or negedge I_Rst_N) begin
    if (!I_Rst_N) begin
      s0 <= 1'b1;
      s1 <= 1'b1;
      s2 <= 1'b1;
    end else begin
      s0 <= I_Rxd;
      s1 <= s0;
      s2 <= s1;
    end
  end

  assign fall    = s2 & ~s1;
  // Third sample is the live line at the decision point itself.
  assign maj     = (smp[0] & smp[1]) | (smp[0] & s1) | (smp[1] & s1);
  assign bit_end = (cnt == C_LAST);
  assign dec     = (cnt == C_DEC);

  always_ff @(posedge I_Clk or negedge I_Rst_N) begin
    if (!I_Rst_N) begin
      state <= IDLE;
      cnt   <= 16'd0;
      idx   <= 3'd0;
      smp   <= 2'b11;
      shreg <= 8'h00;
      data  <= 8'h00;
      valid <= 1'b0;
      ferr  <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      idx   <= idx_nxt;
      smp   <= smp_nxt;
      shreg <= shreg_nxt;
      data  <= data_nxt;
      valid <= valid_nxt;
      ferr  <= ferr_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    idx_nxt   = idx;
    smp_nxt   = smp;
    shreg_nxt = shreg;
    data_nxt  = data;
    valid_nxt = 1'b0;
    ferr_nxt  = 1'b0;

    if (state != IDLE) begin
      cnt_nxt = bit_end ? 16'd0 : cnt + 16'd1;
      if (cnt == C_SMP0) smp_nxt[0] = s1;
      if (cnt == C_SMP1) smp_nxt[1] = s1;
    end

    case (state)
      IDLE: begin
        cnt_nxt = 16'd0;
        idx_nxt = 3'd0;
        if (fall) state_nxt = START;
      end
      START: begin
        if (dec && maj) begin
          state_nxt = IDLE;
          cnt_nxt   = 16'd0;
        end else if (bit_end) begin
          state_nxt = DATA;
          idx_nxt   = 3'd0;
        end
      end
      DATA: begin
        if (dec) shreg_nxt[idx] = maj;
        if (bit_end) begin
          if (idx == 3'd7) state_nxt = STOP;
          else             idx_nxt   = idx + 3'd1;
        end
      end
      STOP: begin
        // Leave early so a back-to-back start bit is not missed.
        if (dec) begin
          state_nxt = IDLE;
          cnt_nxt   = 16'd0;
          if (maj) begin
            valid_nxt = 1'b1;
            data_nxt  = shreg;
          end else begin
            ferr_nxt  = 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign O_Data      = data;
  assign O_Valid     = valid;
  assign O_Frame_Err = ferr;
  assign O_Busy      = (state != IDLE);

endmodule

// File: tb/tb_rs232_receive.sv
// Scoreboard bench for rs232_receive: frames are serialised from a bit list,
// expected pulses (kind, byte, cycle) are queued and matched by a monitor.
module tb_rs232_receive;

  localparam int N   = 434;
  localparam int H   = 217;
  // Line drops after edge e, S0 sees it at e+1 (t0); pulse cycle is t0+2+9N+H+2.
  localparam int LAT = 1 + 2 + 9 * N + H + 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rxd;
  logic [7:0] o_data;
  logic       o_valid;
  logic       o_ferr;
  logic       o_busy;

  rs232_receive dut (
    .I_Clk       (clk),
    .I_Rst_N     (rst_n),
    .I_Rxd       (rxd),
    .O_Data      (o_data),
    .O_Valid     (o_valid),
    .O_Frame_Err (o_ferr),
    .O_Busy      (o_busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit         is_err;
    logic [7:0] data;
    int         at;
  } ev_t;

  ev_t        exp_q[$];
  int         checks   = 0;
  int         failures = 0;
  logic [7:0] last_good = 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h at cycle %0d", name, act, req, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && (o_valid || o_ferr)) begin
      ev_t ev;
      check("valid_ferr_exclusive", {31'd0, o_valid & o_ferr}, 32'd0);
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_pulse actual valid=%0b ferr=%0b data=0x%0h required none at cycle %0d",
                 o_valid, o_ferr, o_data, cyc);
      end else begin
        ev = exp_q.pop_front();
        check("pulse_kind_ferr", {31'd0, o_ferr}, {31'd0, ev.is_err});
        check("pulse_time", cyc, ev.at);
        check("pulse_data", {24'd0, o_data}, {24'd0, ev.data});
        check("busy_in_pulse", {31'd0, o_busy}, 32'd0);
      end
    end
  end

  task automatic idle(input int n);
    rxd = 1'b1;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic hold_low(input int n);
    rxd = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Caller is always 1 time unit after a rising edge; abort_bit >= 0 resets mid-frame.
  task automatic send_frame(input logic [7:0] d, input int bpc, input bit stop_val,
                            input bit spike, input int abort_bit);
    int         e;
    logic [9:0] fr;
    ev_t        ev;
    fr = {stop_val, d, 1'b0};
    e  = cyc;
    if (abort_bit < 0) begin
      ev.at = e + LAT;
      if (stop_val) begin
        ev.is_err = 1'b0;
        ev.data   = d;
        last_good = d;
      end else begin
        ev.is_err = 1'b1;
        ev.data   = last_good;
      end
      exp_q.push_back(ev);
    end
    for (int b = 0; b < 10; b++) begin
      for (int k = 0; k < bpc; k++) begin
        if (b == abort_bit && k == H) begin
          rxd = 1'b1;
          #2 rst_n = 1'b0;
          #1;
          check("rst_mid_data", {24'd0, o_data}, 32'd0);
          check("rst_mid_valid", {31'd0, o_valid}, 32'd0);
          check("rst_mid_ferr", {31'd0, o_ferr}, 32'd0);
          check("rst_mid_busy", {31'd0, o_busy}, 32'd0);
          last_good = 8'h00;
          repeat (3) @(posedge clk);
          #1 rst_n = 1'b1;
          return;
        end
        rxd = fr[b] ^ (spike && (k == H + 1));
        @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic false_start();
    int e;
    e = cyc;
    hold_low(100);
    rxd = 1'b1;
    while (cyc < e + 221) begin
      @(posedge clk);
      #1;
    end
    check("false_start_busy_hi", {31'd0, o_busy}, 32'd1);
    @(posedge clk);
    #1;
    check("false_start_busy_lo", {31'd0, o_busy}, 32'd0);
  endtask

  initial begin
    int wait_cnt;
    rxd   = 1'b1;
    rst_n = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("reset_data", {24'd0, o_data}, 32'd0);
    check("reset_valid", {31'd0, o_valid}, 32'd0);
    check("reset_ferr", {31'd0, o_ferr}, 32'd0);
    check("reset_busy", {31'd0, o_busy}, 32'd0);
    rst_n = 1'b1;
    idle(20);

    send_frame(8'h55, N, 1'b1, 1'b0, -1);
    idle(30);
    send_frame(8'hA3, N, 1'b1, 1'b0, -1);
    idle(30);

    send_frame(8'h00, N, 1'b1, 1'b0, -1);
    send_frame(8'hFF, N, 1'b1, 1'b0, -1);
    send_frame(8'h81, N, 1'b1, 1'b0, -1);
    idle(30);

    false_start();
    idle(300);
    send_frame(8'h3C, N, 1'b1, 1'b0, -1);
    idle(30);

    send_frame(8'hC5, N, 1'b0, 1'b0, -1);
    hold_low(5 * N);
    idle(50);

    send_frame(8'h96, N, 1'b1, 1'b1, -1);
    idle(30);
    send_frame(8'h5A, 420, 1'b1, 1'b0, -1);
    idle(30);

    send_frame(8'hE7, N, 1'b1, 1'b0, 5);
    idle(30);
    send_frame(8'h7E, N, 1'b1, 1'b0, -1);
    idle(30);

    for (int i = 0; i < 4; i++) begin
      logic [7:0] d;
      d = 8'($urandom);
      send_frame(d, $urandom_range(425, 443), 1'b1, 1'($urandom_range(0, 1)), -1);
      idle($urandom_range(0, 40));
    end
    idle(20);

    wait_cnt = 0;
    while (exp_q.size() != 0 && wait_cnt < 10000) begin
      @(posedge clk);
      wait_cnt++;
    end
    #1;
    check("queue_drained", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rs232_receive.md
# rs232_receive

UART receiver: the receive-side counterpart of the team's RS232 transmitter, using the same framing of 1 start bit, 8 data bits LSB-first, 1 stop bit, no parity. It synchronises the asynchronous line `I_Rxd`, detects start bits, majority-samples each bit at mid-bit, and presents each received byte as a one-cycle valid pulse. Frames with a bad stop bit are flagged instead. It sits between the board RX pin and byte-level consumers such as command parsers and loopback logic.

## Interface
- `P_CLK_FREQ`, default 50_000_000: clock frequency in Hz.
- `P_RS232_BPS`, default 115200: baud rate.
- Derived, not overridable: `P_BPS_CNT = P_CLK_FREQ / P_RS232_BPS` (integer division; 434 at defaults), `P_HALF = P_BPS_CNT / 2` (217). `P_BPS_CNT` must be between 8 and 65535.
- `I_Clk`, input, 1: the single clock.
- `I_Rst_N`, input, 1: asynchronous, active-low reset.
- `I_Rxd`, input, 1: serial line, idle high, asynchronous to `I_Clk`.
- `O_Data`, output, 8: last correctly received byte; held until the next good frame.
- `O_Valid`, output, 1: one-cycle pulse; `O_Data` is new in that same cycle.
- `O_Frame_Err`, output, 1: one-cycle pulse when the stop bit is sampled low.
- `O_Busy`, output, 1: high while the FSM is not in IDLE.

## Operation
- Synchroniser:
  - Three-flop chain `I_Rxd -> S0 -> S1 -> S2`; all three reset to 1.
  - `S1` is the synchronised line. Falling edge = `S2 & ~S1`.
- FSM states: IDLE, START, DATA, STOP. A 16-bit bit-timer `cnt` runs 0..`P_BPS_CNT-1` in every non-IDLE state and is held at 0 in IDLE. A 3-bit index `idx` tracks the data bit.
- Sampling:
  - In each bit, `S1` is captured at `cnt = P_HALF-1`, `P_HALF` and `P_HALF+1`.
  - The bit value is the 2-of-3 majority, decided at `cnt = P_HALF+1` (the "decision point").
- IDLE -> START on a falling edge; `cnt` clears to 0.
- START:
  - Decision 1 (false start / glitch): return to IDLE at the decision point. No output pulses.
  - Decision 0: continue. At `cnt = P_BPS_CNT-1`, go to DATA with `cnt = 0` and `idx = 0`.
- DATA:
  - At the decision point, the majority bit is written into shift-register bit `idx` (LSB first).
  - At `cnt = P_BPS_CNT-1`: if `idx = 7`, go to STOP; otherwise increment `idx`.
- STOP: at the decision point, go to IDLE. The rest of the stop bit is not waited out, so the receiver can resynchronise to a back-to-back start bit.
  - Majority 1: on the next edge, `O_Data` takes the shift register and `O_Valid` is high for 1 cycle.
  - Majority 0: on the next edge, `O_Frame_Err` is high for 1 cycle; `O_Data` is unchanged.
- `O_Valid` and `O_Frame_Err` are never high together.
- After a frame error the line may still be low. No new frame starts until a fresh 1->0 transition is seen on `S1`, so a held-low break produces exactly one `O_Frame_Err`.
- There is no back-pressure. A consumer that misses `O_Valid` loses the byte.
- Reset asserted mid-frame: immediate return to IDLE. All outputs go to reset values and the partial byte is discarded.
- Reset values: `O_Data = 8'h00`, `O_Valid = 0`, `O_Frame_Err = 0`, `O_Busy = 0`; state IDLE, `cnt = 0`, `idx = 0`, synchroniser all 1.

## Timing
- Let t0 be the first `I_Clk` rising edge at which `S0` captures `I_Rxd = 0`.
  - `S1 = 0` at t0+1.
  - The FSM is in START with `cnt = 0` at t0+2.
- STOP is entered at t0+2+9·`P_BPS_CNT`. Its decision point is `P_HALF+1` cycles later.
- `O_Valid` (or `O_Frame_Err`) is high during the cycle starting at t0+2+9·`P_BPS_CNT`+`P_HALF`+2. At defaults this is t0+4127.
- `O_Busy` is high from t0+2 up to and including the STOP decision-point cycle. It is low in the cycle of the `O_Valid`/`O_Frame_Err` pulse.
- A false start releases `O_Busy` at t0+2+`P_HALF`+2.
- Tolerance: cumulative sampling drift must stay within ±`P_HALF`-1 cycles over 10 bits. This is met for baud mismatch up to about 4%.

## Test plan
- Defaults: send 0x55, then 0xA3, both with correct framing at exactly 434 cycles per bit. Expect `O_Valid` pulses at t0+4127 for each, with `O_Data` = 0x55 and then 0xA3. `O_Frame_Err` stays 0.
- Back-to-back frames: send 0x00, 0xFF, 0x81 with no idle gap, the next start bit beginning right after a 434-cycle stop bit. Expect 3 `O_Valid` pulses with the correct bytes in order.
- False start: a low glitch of 100 cycles on an idle line. Expect `O_Busy` high then low, no `O_Valid`, and no `O_Frame_Err`. A following 0x3C frame is received correctly.
- Frame error: send 0xC5 with the stop bit driven low, then hold the line low for 5 bit times. Expect exactly one `O_Frame_Err` pulse, `O_Data` keeping its previous value, and no `O_Valid`.
- Noise and drift:
  - One-cycle inverted spikes at `cnt = P_HALF` in every bit of 0x96 still yield 0x96.
  - Transmitting 0x5A at 420 cycles per bit still yields 0x5A.
- Reset: assert `I_Rst_N` low asynchronously during data bit 4. Expect outputs at reset values immediately and `O_Busy` = 0. After release, the next 0x7E frame is received correctly.
